// File: rtl/mcu51_alu_pkg.sv
// rtl/mcu51_alu_pkg.sv - op codes, PSW bit positions and FSM encoding for the 8051 execute ALU
package mcu51_alu_pkg;

  localparam int OP_W = 6;
  localparam int ITER = 8;

  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_ADDC = 6'd1;
  localparam logic [OP_W-1:0] OP_SUBB = 6'd2;
  localparam logic [OP_W-1:0] OP_INC  = 6'd3;
  localparam logic [OP_W-1:0] OP_DEC  = 6'd4;
  localparam logic [OP_W-1:0] OP_ANL  = 6'd5;
  localparam logic [OP_W-1:0] OP_ORL  = 6'd6;
  localparam logic [OP_W-1:0] OP_XRL  = 6'd7;
  localparam logic [OP_W-1:0] OP_CLR  = 6'd8;
  localparam logic [OP_W-1:0] OP_CPL  = 6'd9;
  localparam logic [OP_W-1:0] OP_RL   = 6'd10;
  localparam logic [OP_W-1:0] OP_RLC  = 6'd11;
  localparam logic [OP_W-1:0] OP_RR   = 6'd12;
  localparam logic [OP_W-1:0] OP_RRC  = 6'd13;
  localparam logic [OP_W-1:0] OP_SWAP = 6'd14;
  localparam logic [OP_W-1:0] OP_DA   = 6'd15;
  localparam logic [OP_W-1:0] OP_MUL  = 6'd16;
  localparam logic [OP_W-1:0] OP_DIV  = 6'd17;
  localparam logic [OP_W-1:0] OP_PASS = 6'd18;

  localparam int PSW_CY = 7;
  localparam int PSW_AC = 6;
  localparam int PSW_OV = 2;
  localparam int PSW_P  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DONE   = 2'd1,
    ST_MUL_IT = 2'd2,
    ST_DIV_IT = 2'd3
  } state_e;

  function automatic logic parity8(input logic [7:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - decoder/CPU to execute-ALU request and result bundle
interface alu_exec_if #(
  parameter int OP_W = 6
);
  logic            alu_en;
  logic [OP_W-1:0] alu_op;
  logic [7:0]      acc_in;
  logic [7:0]      opnd_in;
  logic [7:0]      psw_in;
  logic            busy;
  logic            done;
  logic [7:0]      result;
  logic [7:0]      result_hi;
  logic [7:0]      psw_out;
  logic            psw_we;

  modport master (
    output alu_en, alu_op, acc_in, opnd_in, psw_in,
    input  busy, done, result, result_hi, psw_out, psw_we
  );

  modport slave (
    input  alu_en, alu_op, acc_in, opnd_in, psw_in,
    output busy, done, result, result_hi, psw_out, psw_we
  );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_muldiv #(
  parameter int ITER = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       is_div,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] lo,
  output logic [7:0] hi
);

  localparam int CW = $clog2(ITER);

  logic          run_q;
  logic          div_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    hi_q;
  logic [7:0]    lo_q;
  logic [7:0]    b_q;

  logic [7:0] hi_n;
  logic [7:0] lo_n;
  logic [8:0] sum;
  logic [8:0] shifted;
  logic [9:0] diff;

  // lo/hi are the values after the current step, so the caller can latch them on the last step
  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    hi_n    = hi_q;
    lo_n    = lo_q;
    if (div_q) begin
      shifted = {hi_q, lo_q[7]};
      diff    = {1'b0, shifted} - {2'b00, b_q};
      if (!diff[9]) begin
        hi_n = diff[7:0];
        lo_n = {lo_q[6:0], 1'b1};
      end else begin
        hi_n = shifted[7:0];
        lo_n = {lo_q[6:0], 1'b0};
      end
    end else begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 9'd0);
      hi_n = sum[8:1];
      lo_n = {sum[0], lo_q[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      div_q <= is_div;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
    end else if (run_q) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

  assign busy = run_q;
  assign done = run_q && (cnt_q == CW'(ITER - 1));
  assign lo   = lo_n;
  assign hi   = hi_n;

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - 8051 execute-stage ALU: single-cycle datapath, MUL/DIV sequencing, PSW merge
module alu_exec
  import mcu51_alu_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ITER = 8
) (
  input  logic clk,
  input  logic reset,
  alu_exec_if.slave bus
);

  state_e state_q, state_d;

  logic [OP_W-1:0] op;
  logic [7:0]      a;
  logic [7:0]      b;
  logic            cy;

  assign op = bus.alu_op;
  assign a  = bus.acc_in;
  assign b  = bus.opnd_in;
  assign cy = bus.psw_in[PSW_CY];

  logic [7:0] result_q, result_hi_q, psw_out_q, psw_q;
  logic       psw_we_q;

  logic       md_start, md_div, md_busy, md_done;
  logic [7:0] md_lo, md_hi;
  logic [7:0] md_psw;
  logic       load_sc, load_md;

  logic [7:0] sc_res, sc_psw;
  logic       sc_we;
  logic       cin;
  logic [8:0] s9;
  logic [4:0] s4;
  logic [7:0] s7;
  logic [8:0] t9;
  logic       da_cy;

  alu_muldiv #(.ITER(ITER)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_div),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Single-cycle datapath, evaluated on the live operands of the accepting edge
  always_comb begin
    cin    = 1'b0;
    s9     = '0;
    s4     = '0;
    s7     = '0;
    t9     = '0;
    da_cy  = 1'b0;
    sc_res = a;
    sc_psw = bus.psw_in;
    sc_we  = 1'b1;
    case (op)
      OP_ADD, OP_ADDC, OP_SUBB: begin
        cin = (op == OP_ADD) ? 1'b0 : cy;
        if (op == OP_SUBB) begin
          s9 = {1'b0, a} - {1'b0, b} - {8'd0, cin};
          s4 = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, cin};
          s7 = {1'b0, a[6:0]} - {1'b0, b[6:0]} - {7'd0, cin};
        end else begin
          s9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
          s4 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
          s7 = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
        end
        sc_res         = s9[7:0];
        sc_psw[PSW_CY] = s9[8];
        sc_psw[PSW_AC] = s4[4];
        sc_psw[PSW_OV] = s7[7] ^ s9[8];
      end
      OP_INC:  sc_res = a + 8'd1;
      OP_DEC:  sc_res = a - 8'd1;
      OP_ANL:  sc_res = a & b;
      OP_ORL:  sc_res = a | b;
      OP_XRL:  sc_res = a ^ b;
      OP_CLR:  sc_res = 8'h00;
      OP_CPL:  sc_res = ~a;
      OP_RL:   sc_res = {a[6:0], a[7]};
      OP_RLC: begin
        sc_res         = {a[6:0], cy};
        sc_psw[PSW_CY] = a[7];
      end
      OP_RR:   sc_res = {a[0], a[7:1]};
      OP_RRC: begin
        sc_res         = {cy, a[7:1]};
        sc_psw[PSW_CY] = a[0];
      end
      OP_SWAP: sc_res = {a[3:0], a[7:4]};
      OP_DA: begin
        t9 = {1'b0, a};
        if (a[3:0] > 4'd9 || bus.psw_in[PSW_AC]) t9 = t9 + 9'h006;
        da_cy = cy | t9[8];
        if (t9[7:4] > 4'd9 || da_cy) t9 = {1'b0, t9[7:0]} + 9'h060;
        sc_res         = t9[7:0];
        sc_psw[PSW_CY] = da_cy | t9[8];
      end
      OP_MUL:  sc_res = a;
      // Only reached with B=0; a non-zero divisor goes to the iterative unit
      OP_DIV: begin
        sc_res         = a;
        sc_psw[PSW_CY] = 1'b0;
        sc_psw[PSW_OV] = 1'b1;
      end
      OP_PASS: sc_res = b;
      default: sc_we = 1'b0;
    endcase
    if (sc_we) sc_psw[PSW_P] = parity8(sc_res);
  end

  always_comb begin
    md_psw         = psw_q;
    md_psw[PSW_CY] = 1'b0;
    md_psw[PSW_OV] = (state_q == ST_MUL_IT) ? |md_hi : 1'b0;
    md_psw[PSW_P]  = parity8(md_lo);
  end

  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    md_div   = 1'b0;
    load_sc  = 1'b0;
    load_md  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.alu_en) begin
          if (op == OP_MUL) begin
            state_d  = ST_MUL_IT;
            md_start = 1'b1;
          end else if (op == OP_DIV && b != 8'h00) begin
            state_d  = ST_DIV_IT;
            md_start = 1'b1;
            md_div   = 1'b1;
          end else begin
            state_d = ST_DONE;
            load_sc = 1'b1;
          end
        end
      end
      ST_MUL_IT, ST_DIV_IT: begin
        if (md_done) begin
          state_d = ST_DONE;
          load_md = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      psw_out_q   <= '0;
      psw_we_q    <= 1'b0;
      psw_q       <= '0;
    end else begin
      state_q  <= state_d;
      psw_we_q <= 1'b0;
      if (md_start) psw_q <= bus.psw_in;
      if (load_sc) begin
        result_q    <= sc_res;
        result_hi_q <= b;
        psw_out_q   <= sc_psw;
        psw_we_q    <= sc_we;
      end
      if (load_md) begin
        result_q    <= md_lo;
        result_hi_q <= md_hi;
        psw_out_q   <= md_psw;
        psw_we_q    <= 1'b1;
      end
    end
  end

  assign bus.busy      = md_busy;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.psw_out   = psw_out_q;
  assign bus.psw_we    = psw_we_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec with directed and random operations
module tb_alu_exec;
  import mcu51_alu_pkg::*;

  logic clk = 1'b0;
  logic reset;

  alu_exec_if #(.OP_W(6)) bus();

  alu_exec #(.OP_W(6), .ITER(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_res, exp_hi, exp_psw;
  logic       exp_we;
  int         exp_lat;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf(input int v);
    return (v > 127) || (v < -128);
  endfunction

  // Reference behaviour from the instruction-set definition using integer arithmetic
  task automatic model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] psw);
    int ia, ib, ic, s, sa, sb, t;
    logic c;
    logic [7:0] r;
    ia = int'(a);
    ib = int'(b);
    sa = a[7] ? ia - 256 : ia;
    sb = b[7] ? ib - 256 : ib;
    exp_psw = psw;
    exp_hi  = b;
    exp_we  = 1'b1;
    exp_lat = 1;
    r = a;
    case (op)
      OP_ADD, OP_ADDC: begin
        ic = (op == OP_ADDC) ? int'(psw[7]) : 0;
        s = ia + ib + ic;
        r = s[7:0];
        exp_psw[7] = s > 255;
        exp_psw[6] = (ia % 16 + ib % 16 + ic) > 15;
        exp_psw[2] = ovf(sa + sb + ic);
      end
      OP_SUBB: begin
        ic = int'(psw[7]);
        s = ia - ib - ic;
        r = s[7:0];
        exp_psw[7] = s < 0;
        exp_psw[6] = (ia % 16 - ib % 16 - ic) < 0;
        exp_psw[2] = ovf(sa - sb - ic);
      end
      OP_INC:  begin s = (ia + 1) % 256; r = s[7:0]; end
      OP_DEC:  begin s = (ia + 255) % 256; r = s[7:0]; end
      OP_ANL:  r = a & b;
      OP_ORL:  r = a | b;
      OP_XRL:  r = a ^ b;
      OP_CLR:  r = 8'h00;
      OP_CPL:  begin s = 255 - ia; r = s[7:0]; end
      OP_RL:   begin s = (ia * 2) % 256 + ia / 128; r = s[7:0]; end
      OP_RLC:  begin s = (ia * 2) % 256 + int'(psw[7]); r = s[7:0]; exp_psw[7] = ia >= 128; end
      OP_RR:   begin s = ia / 2 + (ia % 2) * 128; r = s[7:0]; end
      OP_RRC:  begin s = ia / 2 + int'(psw[7]) * 128; r = s[7:0]; exp_psw[7] = (ia % 2) == 1; end
      OP_SWAP: begin s = (ia % 16) * 16 + ia / 16; r = s[7:0]; end
      OP_DA: begin
        t = ia;
        if (t % 16 > 9 || psw[6]) t = t + 6;
        c = psw[7] || (t > 255);
        t = t % 256;
        if (t / 16 > 9 || c) t = t + 96;
        c = c || (t > 255);
        r = t[7:0];
        exp_psw[7] = c;
      end
      OP_MUL: begin
        s = ia * ib;
        r = s[7:0];
        exp_hi = s[15:8];
        exp_psw[7] = 1'b0;
        exp_psw[2] = s > 255;
        exp_lat = 9;
      end
      OP_DIV: begin
        exp_psw[7] = 1'b0;
        if (ib == 0) begin
          exp_psw[2] = 1'b1;
        end else begin
          s = ia / ib;
          r = s[7:0];
          s = ia % ib;
          exp_hi = s[7:0];
          exp_psw[2] = 1'b0;
          exp_lat = 9;
        end
      end
      OP_PASS: r = b;
      default: exp_we = 1'b0;
    endcase
    exp_res = r;
    if (exp_we) exp_psw[0] = ^r;
  endtask

  task automatic drive(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] psw);
    bus.alu_en  = 1'b1;
    bus.alu_op  = op;
    bus.acc_in  = a;
    bus.opnd_in = b;
    bus.psw_in  = psw;
    model(op, a, b, psw);
  endtask

  task automatic check_done(input string tag);
    chk({tag, ".done"}, bus.done, 1'b1);
    chk({tag, ".busy"}, bus.busy, 1'b0);
    chk({tag, ".result"}, bus.result, exp_res);
    chk({tag, ".result_hi"}, bus.result_hi, exp_hi);
    chk({tag, ".psw_out"}, bus.psw_out, exp_psw);
    chk({tag, ".psw_we"}, bus.psw_we, exp_we);
  endtask

  // Called at a negedge; leaves at the negedge of the cycle after done
  task automatic run(input string tag, input logic [5:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] psw, input bit inject);
    drive(op, a, b, psw);
    @(posedge clk);
    @(negedge clk);
    bus.alu_en = 1'b0;
    if (exp_lat == 9) begin
      for (int k = 1; k <= 8; k++) begin
        chk($sformatf("%s.busy_c%0d", tag, k), {bus.busy, bus.done}, 2'b10);
        if (inject && k == 3) begin
          bus.alu_en = 1'b1;
          bus.alu_op = OP_ADD;
          bus.acc_in = 8'h11;
        end
        if (k == 4) bus.alu_en = 1'b0;
        @(negedge clk);
      end
    end
    check_done(tag);
    @(negedge clk);
    chk({tag, ".idle"}, {bus.done, bus.psw_we}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int rop;
    logic [5:0] op;
    logic [7:0] ra, rb, rp;

    reset       = 1'b1;
    bus.alu_en  = 1'b0;
    bus.alu_op  = '0;
    bus.acc_in  = '0;
    bus.opnd_in = '0;
    bus.psw_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.ctl", {bus.busy, bus.done, bus.psw_we}, 3'b000);
    chk("reset.res", {bus.result, bus.result_hi}, 16'h0000);
    chk("reset.psw", bus.psw_out, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    run("add", OP_ADD, 8'h7F, 8'h01, 8'h00, 1'b0);
    chk("add.lit", {bus.result, bus.psw_out}, 16'h8045);
    run("subb", OP_SUBB, 8'h00, 8'h01, 8'h80, 1'b0);
    chk("subb.lit", {bus.result, bus.psw_out}, 16'hFEC1);
    run("mul", OP_MUL, 8'h50, 8'hA0, 8'h00, 1'b1);
    chk("mul.lit", {bus.result_hi, bus.result}, 16'h3200);
    chk("mul.psw", bus.psw_out, 8'h04);
    run("div", OP_DIV, 8'hFB, 8'h12, 8'h00, 1'b0);
    chk("div.lit", {bus.result_hi, bus.result}, 16'h110D);
    chk("div.psw", bus.psw_out, 8'h01);
    run("div0", OP_DIV, 8'h37, 8'h00, 8'h00, 1'b0);
    chk("div0.lit", {bus.result, bus.psw_out}, 16'h3705);
    run("inc_wrap", OP_INC, 8'hFF, 8'h00, 8'hC4, 1'b0);
    chk("inc_wrap.lit", {bus.result, bus.psw_out}, 16'h00C4);
    run("dec_wrap", OP_DEC, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("dec_wrap.lit", {bus.result, bus.psw_out}, 16'hFF00);
    run("illegal", 6'h3F, 8'h12, 8'h34, 8'hA5, 1'b0);
    chk("illegal.lit", {bus.result, bus.psw_out}, 16'h12A5);

    // ADD then DA issued in the DONE cycle
    drive(OP_ADD, 8'h56, 8'h67, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check_done("bb_add");
    chk("bb_add.lit", bus.result, 8'hBD);
    drive(OP_DA, 8'hBD, 8'h00, exp_psw);
    @(posedge clk);
    @(negedge clk);
    bus.alu_en = 1'b0;
    check_done("bb_da");
    chk("bb_da.lit", {bus.result, bus.psw_out}, 16'h2385);
    @(negedge clk);
    chk("bb.idle", bus.done, 1'b0);

    // Reset during MUL aborts without a done pulse
    drive(OP_MUL, 8'h50, 8'hA0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    bus.alu_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort.ctl", {bus.busy, bus.done, bus.psw_we}, 3'b000);
    chk("abort.res", {bus.result, bus.result_hi}, 16'h0000);
    chk("abort.psw", bus.psw_out, 8'h00);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen = seen | bus.done | bus.busy;
    end
    chk("abort.no_done", seen, 1'b0);

    for (int i = 0; i < 150; i++) begin
      rop = $urandom_range(0, 20);
      op  = (rop == 20) ? 6'h3F : 6'(rop);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rp  = 8'($urandom);
      if (op == OP_DIV && $urandom_range(0, 3) == 0) rb = 8'h00;
      run($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, rp, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU for the 8051 core. Sits directly downstream of the instruction decoder.
- Consumes the decoder's alu_en/alu_op pair plus operands staged by the CPU (accumulator, B or operand, PSW).
- Returns the new A, the new B (for MUL/DIV) and an updated PSW.
- Single-cycle ops complete in one cycle; MUL AB and DIV AB are iterative over 8 cycles.

Parameters:
- OP_W, 6, width of alu_op (matches decoder output)
- ITER, 8, MUL/DIV iteration count (operand width; not to be changed independently of 8-bit datapath)

Ports:
- clk  in  1  core oscillator clock
- reset  in  1  synchronous, active-high reset
- alu_en  in  1  start strobe from decoder; sampled only when busy=0
- alu_op  in  6  operation code (package encoding)
- acc_in  in  8  accumulator A operand
- opnd_in  in  8  second operand (B register for MUL/DIV, direct/immediate otherwise)
- psw_in  in  8  current PSW (CY=7, AC=6, OV=2, P=0)
- busy  out  1  high while MUL/DIV iterating
- done  out  1  one-cycle result-valid pulse
- result  out  8  new A value
- result_hi  out  8  new B value (MUL high byte / DIV remainder; else opnd latched)
- psw_out  out  8  updated PSW, valid with done
- psw_we  out  1  PSW write strobe, coincident with done

Behaviour:
- Reset (clk edge with reset=1): state IDLE; busy=0, done=0, psw_we=0, result=0, result_hi=0, psw_out=0. Reset mid-MUL/DIV aborts: no done pulse.
- Operands and op latched on the accepting edge. alu_en while busy=1 is ignored (not queued).
- States:
  - IDLE
  - DONE (done=1, busy=0)
  - MUL_IT
  - DIV_IT
- Accepting a start: alu_en accepted in IDLE or DONE.
  - Single-cycle op -> DONE; done at N+1 for alu_en sampled at edge N. Back-to-back issue every cycle is allowed.
  - MUL/DIV -> MUL_IT/DIV_IT, iteration counter=0; busy=1 for cycles N+1..N+8; DONE at N+9.
- Leaving DONE: DONE -> IDLE if no new accepted alu_en.
- Ops and flag updates:
  - ADD, ADDC, SUBB (borrow = CY): CY = carry/borrow out of bit7; AC = out of bit3; OV = carry6 XOR carry7.
  - INC, DEC, ANL, ORL, XRL, CLR, CPL, RL, RR, SWAP, PASS: only P changes.
  - RLC, RRC: rotate through CY; CY updated.
  - DA: add 0x06 if A[3:0]>9 or AC; then add 0x60 if high nibble>9 or CY. CY is set on carry and never cleared.
  - MUL: shift-add; {result_hi,result} = A*B; CY=0; OV = (product>0xFF).
  - DIV: restoring; result = quotient, result_hi = remainder; CY=0, OV=0.
  - DIV with B=0: no iteration, done at N+1; result=acc_in, result_hi=opnd_in, OV=1, CY=0.
- P = XOR-reduce(result) on every psw_we.
- psw_we=1 with every done, except for illegal op codes.
- Illegal op code: done at N+1, result=acc_in, result_hi=opnd_in, psw_out=psw_in, psw_we=0.
- Bits of psw_out not listed above pass through from latched psw_in.
- Wrap-around: INC 0xFF -> 0x00, DEC 0x00 -> 0xFF; no flags affected except P.

Decomposition:
- Package mcu51_alu_pkg:
  - op code constants: ADD 0, ADDC 1, SUBB 2, INC 3, DEC 4, ANL 5, ORL 6, XRL 7, CLR 8, CPL 9, RL 10, RLC 11, RR 12, RRC 13, SWAP 14, DA 15, MUL 16, DIV 17, PASS 18
  - PSW bit index constants
  - state encoding
- Sub-module alu_muldiv: iterative 8-step shift-add multiplier / restoring divider with start/busy/done. alu_exec holds the single-cycle datapath, FSM and flag merge.

Test Plan:
- ADD acc=0x7F, opnd=0x01, psw=0x00 -> done at N+1, result=0x80, CY=0, AC=1, OV=1, P=1, psw_we=1.
- SUBB acc=0x00, opnd=0x01, CY=1 -> result=0xFE, CY=1, AC=1, OV=0, P=1.
- MUL acc=0x50, opnd=0xA0 -> busy N+1..N+8, done N+9, result=0x00, result_hi=0x32, OV=1, CY=0, P=0. An alu_en at N+3 is ignored.
- DIV acc=0xFB, opnd=0x12 -> done N+9, result=0x0D, result_hi=0x11, OV=0, P=1. DIV with opnd=0x00 -> done N+1, OV=1, result=acc_in.
- ADD 0x56+0x67 then DA (issued in the DONE cycle) -> 0xBD then 0x23 with CY=1; done pulses on consecutive cycles.
- MUL started, reset=1 at N+4 -> busy=0 and all outputs 0 from N+5; no done pulse. alu_op=0x3F -> done N+1, psw_we=0, result=acc_in.
